// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
// Shared definitions for the FIFO write arbiter: FSM state encoding and the
// default requester count / data width used by fifo_wr_arbiter.
// The LOCK state exists only when FIFO_ARB_LOCK_EN is defined.
package fifo_wr_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_STALL = 2'd2
`ifdef FIFO_ARB_LOCK_EN
    ,
    ST_LOCK  = 2'd3
`endif
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker
// Round-robin priority selector. Searches the request vector starting at the
// requester after last_gnt, wrapping from NUM_REQ-1 to 0, and returns a
// one-hot pick of the first active requester (all-zero when req == 0).
// Ports:
//   req      in  NUM_REQ  active requests
//   last_gnt in  IDX_W    index of the most recently granted requester
//   pick     out NUM_REQ  one-hot winner
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic [NUM_REQ-1:0] pick
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that funnels NUM_REQ write requesters into a single
// downstream FIFO. Grants are combinational; the FIFO write strobe and data
// are registered, so a grant at one edge produces the write one cycle later.
// Grants are withheld when the FIFO is full, or when it has one free slot and
// a registered write is already about to land in it.
// Optional feature macro: FIFO_ARB_LOCK_EN adds req_lock and a LOCK state in
// which the granted agent keeps exclusive access while it holds req+req_lock.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   req          per-requester write request
//   req_data     packed write data, requester i at [i*WIDTH +: WIDTH]
//   req_lock     burst-lock request (FIFO_ARB_LOCK_EN only)
//   gnt          one-hot grant; req_data[i] is consumed at this edge
//   fifo_full    downstream FIFO full
//   fifo_afull   downstream FIFO has exactly one free slot
//   fifo_wr_en   registered write strobe
//   fifo_wr_data registered write data
//   busy         registered, high whenever the FSM is not idle
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
`ifdef FIFO_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     fifo_full,
  input  logic                     fifo_afull,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
  logic               wr_en_q, wr_en_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] gnt_int;
  logic [IDX_W-1:0]   gnt_idx;
  logic [WIDTH-1:0]   gnt_data;
  logic               any_gnt;
  logic               ok;
  logic               lock_hold;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req      (req),
    .last_gnt (last_gnt_q),
    .pick     (pick)
  );

  always_comb begin
    // A write already registered for this cycle consumes the last free slot
    // signalled by afull, so a new grant must wait.
    ok        = !fifo_full && !(fifo_afull && wr_en_q);
    lock_hold = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
    // In LOCK the owner is always last_gnt_q: it was the last agent granted.
    lock_hold = (state_q == ST_LOCK) && req[last_gnt_q] && req_lock[last_gnt_q];
`endif
    cand = pick;
    if (lock_hold) begin
      cand             = '0;
      cand[last_gnt_q] = 1'b1;
    end
    gnt_int = (ok && !reset) ? cand : '0;

    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_int[i]) begin
        gnt_idx  = IDX_W'(i);
        gnt_data = req_data[i*WIDTH +: WIDTH];
      end
    end
    any_gnt = |gnt_int;

    wr_en_d    = any_gnt;
    wr_data_d  = any_gnt ? gnt_data : wr_data_q;
    last_gnt_d = any_gnt ? gnt_idx : last_gnt_q;

    state_d = state_q;
    if (lock_hold) begin
`ifdef FIFO_ARB_LOCK_EN
      state_d = ST_LOCK;
`endif
    end else if (any_gnt) begin
      state_d = ST_GRANT;
`ifdef FIFO_ARB_LOCK_EN
      if (req_lock[gnt_idx]) state_d = ST_LOCK;
`endif
    end else if (req == '0) begin
      state_d = ST_IDLE;
    end else begin
      state_d = ST_STALL;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= IDX_W'(NUM_REQ - 1);
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt          = gnt_int;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=32). A behavioural
// model predicts grant, write strobe/data and busy every cycle; directed
// scenarios add literal expectations. Honours FIFO_ARB_LOCK_EN when defined.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_lock;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic           fifo_afull;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
  logic           busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
`ifdef FIFO_ARB_LOCK_EN
    .req_lock     (req_lock),
`endif
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_last  = N - 1;
  int           m_owner = -1;
  bit           m_wr_en = 0;
  logic [W-1:0] m_data  = '0;
  bit           m_busy  = 0;
  int           n_last;
  int           n_owner;
  bit           n_wr_en;
  logic [W-1:0] n_data;
  bit           n_busy;
  bit           chk_en  = 0;

  always @(negedge clk) begin
    bit           ok;
    bit           hold;
    int           g;
    logic [N-1:0] exp_gnt;
    ok   = !fifo_full && !(fifo_afull && m_wr_en);
    hold = 0;
`ifdef FIFO_ARB_LOCK_EN
    hold = (m_owner >= 0) && req[m_owner] && req_lock[m_owner];
`endif
    g = -1;
    if (!reset && ok) begin
      if (hold) g = m_owner;
      else
        for (int k = 1; k <= N; k++)
          if (g < 0 && req[(m_last + k) % N]) g = (m_last + k) % N;
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    if (chk_en) begin
      check("model_gnt", gnt, exp_gnt);
      check("model_wr_en", fifo_wr_en, m_wr_en);
      check("model_wr_data", fifo_wr_data, m_data);
      check("model_busy", busy, m_busy);
    end
    if (reset) begin
      n_wr_en = 0; n_data = '0; n_last = N - 1; n_busy = 0; n_owner = -1;
    end else begin
      n_wr_en = (g >= 0);
      n_data  = (g >= 0) ? req_data[g*W +: W] : m_data;
      n_last  = (g >= 0) ? g : m_last;
      n_busy  = (req != '0);
      if (hold) n_owner = m_owner;
      else if (g >= 0 && req_lock[g]) n_owner = g;
      else n_owner = -1;
    end
  end

  always @(posedge clk) begin
    if (reset) chk_en = 1;
    m_wr_en = n_wr_en;
    m_data  = n_data;
    m_last  = n_last;
    m_busy  = n_busy;
    m_owner = n_owner;
  end

  // ---------------- stimulus ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [W-1:0] exp_d [8];
  logic [N-1:0] one_hot;

  initial begin
    n_last = N - 1; n_owner = -1; n_wr_en = 0; n_data = '0; n_busy = 0;
    reset = 1; req = '0; req_data = '0; req_lock = '0;
    fifo_full = 0; fifo_afull = 0;
    next_cyc();
    next_cyc();
    at_neg();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_wr_data", fifo_wr_data, 32'h0);
    check("rst_busy", busy, 1'b0);

    // single request, empty FIFO
    next_cyc();
    reset = 0; req = 4'b0001; req_data[0 +: W] = 32'hA5A5_0001;
    at_neg();
    check("single_gnt", gnt, 4'b0001);
    next_cyc();
    req = '0;
    at_neg();
    check("single_wr_en", fifo_wr_en, 1'b1);
    check("single_wr_data", fifo_wr_data, 32'hA5A5_0001);

    // all agents requesting: strict rotation, back-to-back writes
    next_cyc();
    reset = 1;
    next_cyc();
    reset = 0; req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int a = 0; a < N; a++) req_data[a*W +: W] = $urandom;
      exp_d[k] = req_data[(k % N)*W +: W];
      one_hot = '0;
      one_hot[k % N] = 1'b1;
      at_neg();
      check("rot_gnt", gnt, one_hot);
      if (k > 0) begin
        check("rot_wr_en", fifo_wr_en, 1'b1);
        check("rot_wr_data", fifo_wr_data, exp_d[k-1]);
      end
      next_cyc();
    end
    req = '0;
    at_neg();
    check("rot_last_wr_en", fifo_wr_en, 1'b1);
    check("rot_last_wr_data", fifo_wr_data, exp_d[7]);

    // almost-full with a write pending stalls one cycle
    next_cyc();
    req = 4'b0001;
    at_neg();
    check("afull_pre_gnt", gnt, 4'b0001);
    next_cyc();
    req = 4'b0010; fifo_afull = 1; req_data[W +: W] = 32'h1234_5678;
    at_neg();
    check("afull_wr_en", fifo_wr_en, 1'b1);
    check("afull_gnt", gnt, 4'b0000);
    next_cyc();
    fifo_afull = 0;
    at_neg();
    check("afull_stall_busy", busy, 1'b1);
    check("afull_release_gnt", gnt, 4'b0010);
    next_cyc();
    req = '0;
    at_neg();
    check("afull_wr_data", fifo_wr_data, 32'h1234_5678);

    // FIFO full for 5 cycles
    next_cyc();
    reset = 1;
    next_cyc();
    reset = 0; fifo_full = 1; req = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("full_gnt", gnt, 4'b0000);
      check("full_wr_en", fifo_wr_en, 1'b0);
      if (i > 0) check("full_busy", busy, 1'b1);
      next_cyc();
    end
    fifo_full = 0;
    at_neg();
    check("full_rel_gnt0", gnt, 4'b0001);
    next_cyc();
    req = 4'b0100;
    at_neg();
    check("full_rel_gnt2", gnt, 4'b0100);
    next_cyc();
    req = '0;

    // reset during a pending write
    next_cyc();
    req = 4'b1111;
    next_cyc();
    reset = 1;
    at_neg();
    check("rstmid_gnt", gnt, 4'b0000);
    check("rstmid_pending", fifo_wr_en, 1'b1);
    next_cyc();
    reset = 0;
    at_neg();
    check("rstmid_wr_en", fifo_wr_en, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_first_gnt", gnt, 4'b0001);
    next_cyc();
    req = '0;

`ifdef FIFO_ARB_LOCK_EN
    // burst lock by agent 2
    next_cyc();
    reset = 1;
    next_cyc();
    reset = 0; req = 4'b0010;
    next_cyc();
    req = 4'b1111; req_lock = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("lock_gnt", gnt, 4'b0100);
      next_cyc();
    end
    req_lock = '0;
    at_neg();
    check("lock_release_gnt", gnt, 4'b1000);
    next_cyc();
    req = '0;
`endif

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      next_cyc();
      reset      = ($urandom_range(99) == 0);
      req        = N'($urandom);
      fifo_full  = ($urandom_range(3) == 0);
      fifo_afull = ($urandom_range(9) < 3);
      for (int a = 0; a < N; a++) req_data[a*W +: W] = $urandom;
`ifdef FIFO_ARB_LOCK_EN
      req_lock   = N'($urandom) & N'($urandom);
`endif
    end
    next_cyc();
    at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
